xlr8_fmul: RTL and testbench

XLR8_FMUL -- requirements
Module: xlr8_fmul

---
 rtl/xlr8_float_pkg.sv | 23 ++
 rtl/xlr8_fround.sv | 46 ++++
 rtl/xlr8_fmul.sv | 119 +++++++++++
 tb/tb_xlr8_fmul.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xlr8_float_pkg.sv
// Shared single-precision constants, special-case encoding and operand classification
// for the xlr8 floating-point iterative units.
package xlr8_float_pkg;

   localparam int          EXP_W  = 8;
   localparam int          FRAC_W = 23;
   localparam int          MANT_W = FRAC_W + 1;
   localparam int          BIAS   = 127;
   localparam logic [31:0] QNAN   = 32'h7fffffff;

   typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fcls_t;
   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

   // Width-agnostic: callers reduce exponent/fraction to flags. Exponent 0 is zero even with a fraction.
   function automatic fcls_t classify(input logic exp_zero, input logic exp_ones, input logic frac_zero);
      if (exp_zero)
         return CLS_ZERO;
      else if (exp_ones)
         return frac_zero ? CLS_INF : CLS_NAN;
      return CLS_NORM;
   endfunction

endpackage

// File: rtl/xlr8_fround.sv
// Combinational normalise + round-to-nearest-even of a raw mantissa product.
// Zero latency; no flow control.
module xlr8_fround #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                        sign,
   input  logic signed [EXP_W+1:0]     exp_sum,
   input  logic [2*(FRAC_W+1)-1:0]     prod,
   output logic [EXP_W+FRAC_W:0]       res
);
   localparam int MANT_W = FRAC_W + 1;
   localparam int PW     = 2 * MANT_W;
   localparam int EW     = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   logic [PW-1:0]          norm;
   logic signed [EW-1:0]   exp_n;
   logic signed [EW-1:0]   exp_f;
   logic [MANT_W-1:0]      mant;
   logic [MANT_W:0]        mant_r;
   logic                   guard;
   logic                   rnd;
   logic                   sticky;
   logic                   rnd_up;

   always_comb begin
      // Align so the leading one always sits in the top bit.
      norm   = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
      exp_n  = exp_sum + EW'(prod[PW-1]);
      mant   = norm[PW-1 -: MANT_W];
      guard  = norm[PW-1-MANT_W];
      rnd    = norm[PW-2-MANT_W];
      sticky = |norm[PW-3-MANT_W:0];
      rnd_up = guard & (rnd | sticky | mant[0]);
      mant_r = {1'b0, mant} + (MANT_W+1)'(rnd_up);
      // A carry out leaves the fraction field all zero, i.e. mantissa 1.0.
      exp_f  = exp_n + EW'(mant_r[MANT_W]);
      res    = {sign, exp_f[EXP_W-1:0], mant_r[FRAC_W-1:0]};
      if (exp_f >= EXP_MAX)
         res = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else if (exp_f[EW-1] || exp_f == '0)
         res = {sign, {(EXP_W+FRAC_W){1'b0}}};
   end

endmodule

// File: rtl/xlr8_fmul.sv
// Iterative shift-and-add single-precision multiplier, one multiplier bit per enabled clock.
// Latency MANT_W enabled cycles (data independent); starts while busy are dropped, clken stalls everything.
module xlr8_fmul #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clken,
   input  logic [EXP_W+FRAC_W:0] a,
   input  logic [EXP_W+FRAC_W:0] b,
   input  logic                  start,
   output logic [EXP_W+FRAC_W:0] p_out,
   output logic                  busy,
   output logic                  done
);
   import xlr8_float_pkg::*;

   localparam int MANT_W = FRAC_W + 1;
   localparam int W      = EXP_W + FRAC_W + 1;
   localparam int PW     = 2 * MANT_W;
   localparam int CNT_W  = $clog2(MANT_W + 1);
   localparam int BIAS_L = (1 << (EXP_W - 1)) - 1;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [PW-1:0]          acc, acc_nxt, mcand;
   logic [MANT_W-1:0]      mplier;
   logic                   sign_q;
   logic signed [EXP_W+1:0] exp_q, exp_sum;
   spec_t                  spec_q, spec_nxt;
   fcls_t                  cls_a, cls_b;
   logic                   accept, step, fire;
   logic [W-1:0]           rnd_res, res;

   assign accept  = clken & start & (state == ST_IDLE);
   assign step    = clken & (state == ST_RUN);
   assign fire    = step & (cnt == CNT_W'(MANT_W - 1));
   assign acc_nxt = mplier[0] ? acc + mcand : acc;
   assign busy    = (state == ST_RUN);
   assign exp_sum = (EXP_W+2)'({2'b00, a[W-2 -: EXP_W]}) + (EXP_W+2)'({2'b00, b[W-2 -: EXP_W]})
                    - (EXP_W+2)'(BIAS_L);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_RUN;
         ST_RUN:  if (fire)   state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cls_a    = classify(a[W-2 -: EXP_W] == '0, &a[W-2 -: EXP_W], a[FRAC_W-1:0] == '0);
      cls_b    = classify(b[W-2 -: EXP_W] == '0, &b[W-2 -: EXP_W], b[FRAC_W-1:0] == '0);
      spec_nxt = SP_NONE;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
          (cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_b == CLS_INF && cls_a == CLS_ZERO))
         spec_nxt = SP_NAN;
      else if (cls_a == CLS_INF || cls_b == CLS_INF)
         spec_nxt = SP_INF;
      else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
         spec_nxt = SP_ZERO;
   end

   // Rounds the accumulator including the final partial product, so p_out lands on the done edge.
   xlr8_fround #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
      .sign    (sign_q),
      .exp_sum (exp_q),
      .prod    (acc_nxt),
      .res     (rnd_res)
   );

   always_comb begin
      case (spec_q)
         SP_NAN:  res = W'(QNAN);
         SP_INF:  res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         SP_ZERO: res = {sign_q, {(W-1){1'b0}}};
         default: res = rnd_res;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         sign_q <= 1'b0;
         exp_q  <= '0;
         spec_q <= SP_NONE;
         p_out  <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= fire;
         if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{MANT_W{1'b0}}, 1'b1, a[FRAC_W-1:0]};
            mplier <= {1'b1, b[FRAC_W-1:0]};
            sign_q <= a[W-1] ^ b[W-1];
            exp_q  <= exp_sum;
            spec_q <= spec_nxt;
         end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= fire ? '0 : cnt + 1'b1;
         end
         if (fire)
            p_out <= res;
      end
   end

endmodule

// File: tb/tb_xlr8_fmul.sv
// Scoreboard bench for xlr8_fmul: directed spec vectors, stall/ignore/reset scenarios,
// then random operands against an integer-arithmetic reference model.
module tb_xlr8_fmul;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        clken = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic [31:0] p_out;
   logic        busy;
   logic        done;

   xlr8_fmul dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clken (clken),
      .a     (a),
      .b     (b),
      .start (start),
      .p_out (p_out),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          en_at;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp     = 0;
   int          n_bad     = 0;
   int          en_edges  = 0;
   int          accept_at = 0;
   bit          active    = 1'b0;
   logic [31:0] exp_pout  = '0;

   always @(posedge clk)
      if (rst_n && clken) en_edges++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: exact 48-bit integer product, then round-half-even by remainder comparison.
   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
      logic            s;
      int              ex, ey, e, k;
      logic [22:0]     fx, fy;
      longint unsigned p, q, rem, half;
      bit              nan_x, nan_y, inf_x, inf_y, zer_x, zer_y;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      fx = x[22:0];
      fy = y[22:0];
      nan_x = (ex == 255) && (fx != 0);
      nan_y = (ey == 255) && (fy != 0);
      inf_x = (ex == 255) && (fx == 0);
      inf_y = (ey == 255) && (fy == 0);
      zer_x = (ex == 0);
      zer_y = (ey == 0);
      if (nan_x || nan_y || (inf_x && zer_y) || (inf_y && zer_x)) return 32'h7fffffff;
      if (inf_x || inf_y) return {s, 8'hff, 23'h0};
      if (zer_x || zer_y) return {s, 31'h0};
      p = (64'd8388608 + 64'(fx)) * (64'd8388608 + 64'(fy));
      e = ex + ey - 127;
      k = 23;
      if (p >= (64'd1 << 47)) begin
         k = 24;
         e = e + 1;
      end
      q    = p >> k;
      rem  = p - (q << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hff, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [7:0]  e;
      logic [22:0] f;
      logic        s;
      int          sel;
      sel = $urandom_range(0, 15);
      s   = 1'($urandom_range(0, 1));
      f   = 23'($urandom);
      if (sel == 0)       e = 8'h00;
      else if (sel == 1)  e = 8'hff;
      else if (sel < 9)   e = 8'($urandom_range(100, 154));
      else                e = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 3) == 0) f = f & 23'h7ff800;
      if (sel == 1 && $urandom_range(0, 1) == 0) f = '0;
      return {s, e, f};
   endfunction

   // Monitor: pops on every done and holds p_out/busy to the bench's own expectation every cycle.
   always @(negedge clk) begin
      exp_t item;
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
               item = sb.pop_front();
               check("done_latency", en_edges, item.en_at);
               exp_pout = item.res;
            end
         end
         check("p_out", p_out, exp_pout);
         check("busy", {31'b0, busy}, {31'b0, active && (en_edges < accept_at + 24)});
      end
   end

   // mode 0: clken high; 1: random clken stalls; 2: extra start while busy; 3: clken low 5 cycles mid-op
   task automatic do_mul(input logic [31:0] x, input logic [31:0] y, input logic [31:0] req, input int mode);
      exp_t item;
      int   cyc;
      bit   seen;
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      clken = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      accept_at  = en_edges;
      active     = 1'b1;
      item.res   = req;
      item.en_at = en_edges + 24;
      sb.push_back(item);
      a = $urandom;
      b = $urandom;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen = 1'b1;
         end else begin
            clken = 1'b1;
            start = 1'b0;
            case (mode)
               1: clken = ($urandom_range(0, 3) != 0);
               2: start = (cyc == 5);
               3: clken = !(cyc >= 8 && cyc < 13);
               default: ;
            endcase
         end
      end
      start  = 1'b0;
      clken  = 1'b1;
      active = 1'b0;
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done within 400 cycles, required one for %h*%h", x, y);
      end
   endtask

   task automatic reset_mid_op();
      int n;
      @(negedge clk);
      a     = 32'h40000000;
      b     = 32'h40400000;
      start = 1'b1;
      clken = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      accept_at = en_edges;
      active    = 1'b1;
      n = 0;
      while (en_edges < accept_at + 10 && n < 30) begin
         @(negedge clk);
         n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_p_out", p_out, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      active   = 1'b0;
      exp_pout = '0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
   endtask

   logic [31:0] dir_a[12] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h3FFFFFFF,
                              32'h7F800000, 32'hFF800000, 32'h7F000000, 32'h00800000,
                              32'h00000001, 32'h00400000, 32'h3FC00000, 32'h40000000};
   logic [31:0] dir_b[12] = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3F800001,
                              32'h00000000, 32'h40000000, 32'h7F000000, 32'h00800000,
                              32'h3F800000, 32'hBF800000, 32'h3FC00000, 32'h40400000};
   logic [31:0] dir_p[12] = '{32'h40C00000, 32'h40100000, 32'h3F800002, 32'h40000000,
                              32'h7FFFFFFF, 32'hFF800000, 32'h7F800000, 32'h00000000,
                              32'h00000000, 32'h80000000, 32'h40100000, 32'h40C00000};
   int          dir_m[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3};

   initial begin
      logic [31:0] x, y;
      repeat (3) @(negedge clk);
      check("reset_p_out", p_out, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      rst_n = 1'b1;
      clken = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 12; i++)
         do_mul(dir_a[i], dir_b[i], dir_p[i], dir_m[i]);

      reset_mid_op();
      do_mul(32'h40000000, 32'h40000000, 32'h40800000, 0);

      for (int i = 0; i < 150; i++) begin
         x = rnd_op();
         y = rnd_op();
         do_mul(x, y, model(x, y), int'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
